// File: rtl/param_calculator.sv
// Push-button binary calculator: WRITE/READ register file, add/subtract, and a
// sequential double-dabble converter driving NDIG seven-segment digits.
module param_calculator #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    parameter int NDIG  = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [9:0]        pb,
    output logic [7*NDIG-1:0] ss,
    output logic              red,
    output logic              blue
);

    localparam int SW = (NREG > 2) ? 2 : 1;
    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, WRITE, RD_A, RD_B, RD_OP, CONV, SHOW} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1100111;
            default: return 7'b0000000;
        endcase
    endfunction

    logic [9:0] sync1_q, sync2_q, prev_q, edges, btn;
    logic [2:0] arm_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            arm_q   <= '0;
        end else begin
            sync1_q <= pb;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            arm_q   <= {arm_q[1:0], 1'b1};
        end
    end

    // Edges stay masked until the synchronizer has refilled, so a button held
    // through reset release does not look like a fresh press.
    assign edges = arm_q[2] ? (sync2_q & ~prev_q) : '0;
    assign btn   = ((edges & (edges - 10'd1)) == '0) ? edges : '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] entry_q, entry_d, a_q, a_d, b_q, b_d, r_q, r_d;
    logic             red_q, red_d, force_q;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             sel_hit;
    logic [SW-1:0]    sel_idx;
    logic [WIDTH:0]   sum;
    logic             done_q;

    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NREG; k++) begin
            if (btn[6+k]) begin
                sel_hit = 1'b1;
                sel_idx = SW'(k);
            end
        end
    end

    assign sum = {1'b0, a_q} + {1'b0, b_q};

    // NOTE: every next-state variable gets its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        red_d   = red_q;
        regs_d  = regs_q;
        if (state_q == CONV) begin
            if (done_q && !force_q) state_d = SHOW;
        end else if (btn[2]) begin
            state_d = WRITE;
            entry_d = '0;
            red_d   = 1'b0;
        end else if (btn[3]) begin
            state_d = RD_A;
            red_d   = 1'b0;
        end else begin
            case (state_q)
                WRITE: begin
                    if (btn[0] || btn[1]) begin
                        entry_d = {entry_q[WIDTH-2:0], btn[1]};
                    end else if (sel_hit) begin
                        regs_d[sel_idx] = entry_q;
                        entry_d         = '0;
                    end
                end
                RD_A: if (sel_hit) begin
                    a_d     = regs_q[sel_idx];
                    state_d = RD_B;
                end
                RD_B: if (sel_hit) begin
                    b_d     = regs_q[sel_idx];
                    state_d = RD_OP;
                end
                RD_OP: begin
                    if (btn[4]) begin
                        r_d     = sum[WIDTH-1:0];
                        red_d   = sum[WIDTH];
                        state_d = CONV;
                    end else if (btn[5]) begin
                        r_d     = (a_q >= b_q) ? a_q - b_q : '0;
                        red_d   = (a_q < b_q);
                        state_d = CONV;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the register file is small and must read as 0 after reset, so it
    // sits in the async reset branch like every other state element.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            entry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            red_q   <= 1'b0;
            force_q <= 1'b0;
            for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            red_q   <= red_d;
            force_q <= (state_d == CONV) && (state_q != CONV);
            regs_q  <= regs_d;
        end
    end

    logic [WIDTH-1:0] disp, last_q, bin_q;
    logic [BW-1:0]    bcd_q, bcd_adj;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, start;
    logic [7*NDIG-1:0] ss_q, ss_enc;

    always_comb begin
        disp = '0;
        if (state_q == WRITE) disp = entry_q;
        else if (state_q == CONV || state_q == SHOW) disp = r_q;
    end

    // Entering CONV always converts, even when R equals the value on display.
    assign start = force_q || (disp != last_q);

    always_comb begin
        bcd_adj = bcd_q;
        ss_enc  = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            ss_enc[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_q <= '0;
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ss_q   <= {NDIG{7'b0111111}};
        end else begin
            done_q <= 1'b0;
            if (done_q) ss_q <= ss_enc;
            if (start) begin
                last_q <= disp;
                bin_q  <= disp;
                bcd_q  <= '0;
                cnt_q  <= CW'(WIDTH);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                bcd_q  <= {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
                bin_q  <= {bin_q[WIDTH-2:0], 1'b0};
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign ss   = ss_q;
    assign red  = red_q;
    assign blue = (state_q == RD_A) || (state_q == RD_B) || (state_q == RD_OP);

endmodule
